// File: rtl/aes_loader_pkg.sv
// Shared types and sizing for the AES input loader.
package aes_loader_pkg;

  localparam int unsigned WORD_W          = 32;
  localparam int unsigned BLOCK_W         = 128;
  localparam int unsigned WORDS_PER_BLOCK = 4;
  localparam int unsigned SLOT_W          = $clog2(WORDS_PER_BLOCK);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    RUN     = 2'd1,
    GAP     = 2'd2
  } state_e;

endpackage

// File: rtl/aes_word_assembler.sv
// Slotted 128-bit register filled one 32-bit word at a time, first word at the MSBs.
// The slot counter wraps mod 4; full_q marks that the 4th slot was written, so
// "count == 4" is represented as {full_q, cnt_q == 0}. A write to slot 0 drops full_q.
module aes_word_assembler
  import aes_loader_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               we,
  input  logic [WORD_W-1:0]  word_in,
  output logic [BLOCK_W-1:0] block_q,
  output logic [SLOT_W-1:0]  cnt_q,
  output logic               full_q
);

  logic [BLOCK_W-1:0] block_d;
  logic [SLOT_W-1:0]  cnt_d;
  logic               full_d;

  // Next-state: clear rewinds the counter only, a write fills the current slot.
  always_comb begin
    block_d = block_q;
    cnt_d   = cnt_q;
    full_d  = full_q;
    if (clr) begin
      cnt_d  = '0;
      full_d = 1'b0;
    end else if (we) begin
      for (int unsigned i = 0; i < WORDS_PER_BLOCK; i++) begin
        if (cnt_q == SLOT_W'(i)) begin
          block_d[BLOCK_W-1-i*WORD_W -: WORD_W] = word_in;
        end
      end
      cnt_d  = cnt_q + 1'b1;
      full_d = (cnt_q == SLOT_W'(WORDS_PER_BLOCK - 1));
    end
  end

  // Registers with synchronous reset to an empty, zeroed block.
  always_ff @(posedge clk) begin
    if (rst) begin
      block_q <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
    end else begin
      block_q <= block_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
    end
  end

endmodule

// File: rtl/aes_input_loader.sv
// Stages plaintext and key words into 128-bit blocks and sequences AES_en
// through RUN (until completion or timeout) and a fixed low GAP.
module aes_input_loader
  import aes_loader_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 64,
  parameter int unsigned GAP_CYC     = 2,
  parameter int unsigned CNT_W       = 16
) (
  input  logic               AES_clk,
  input  logic               AES_rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WORD_W-1:0]  in_word,
  input  logic               in_is_key,
  output logic               AES_en,
  output logic [BLOCK_W-1:0] AES_data_in,
  output logic [BLOCK_W-1:0] AES_key_in,
  input  logic               AES_data_out_valid,
  output logic               busy,
  output logic               timeout_err,
  output logic [CNT_W-1:0]   blocks_done
);

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);
  localparam logic [7:0]  GAP_LAST = 8'(GAP_CYC - 1);

  state_e             state_q, state_d;
  logic               en_q, en_d;
  logic [15:0]        tmo_cnt_q, tmo_cnt_d;
  logic [7:0]         gap_cnt_q, gap_cnt_d;
  logic [CNT_W-1:0]   blocks_q, blocks_d;
  logic               terr_q, terr_d;
  logic               busy_q, busy_d;

  logic               clr_data;
  logic               data_we, key_we;
  logic [SLOT_W-1:0]  data_cnt, key_cnt;
  logic               data_full, key_ok;
  logic               data_cnt4;
  logic               launch_pending;

  assign data_cnt4      = data_full && (data_cnt == '0);
  assign launch_pending = data_cnt4 && key_ok && (key_cnt == '0);
  assign in_ready       = (state_q == COLLECT) && !(data_cnt4 && !in_is_key) && !launch_pending;
  assign data_we        = in_valid && in_ready && !in_is_key;
  assign key_we         = in_valid && in_ready && in_is_key;

  aes_word_assembler u_data (
    .clk     (AES_clk),
    .rst     (AES_rst),
    .clr     (clr_data),
    .we      (data_we),
    .word_in (in_word),
    .block_q (AES_data_in),
    .cnt_q   (data_cnt),
    .full_q  (data_full)
  );

  // Key full flag doubles as key_ok: set by the 4th word, dropped by the next 1st word.
  aes_word_assembler u_key (
    .clk     (AES_clk),
    .rst     (AES_rst),
    .clr     (1'b0),
    .we      (key_we),
    .word_in (in_word),
    .block_q (AES_key_in),
    .cnt_q   (key_cnt),
    .full_q  (key_ok)
  );

  // Sequencer next-state: launch, run with timeout, fixed gap before collecting again.
  always_comb begin
    state_d   = state_q;
    en_d      = en_q;
    tmo_cnt_d = tmo_cnt_q;
    gap_cnt_d = gap_cnt_q;
    blocks_d  = blocks_q;
    terr_d    = terr_q;
    clr_data  = 1'b0;
    unique case (state_q)
      COLLECT: begin
        if (launch_pending) begin
          state_d   = RUN;
          en_d      = 1'b1;
          tmo_cnt_d = '0;
        end
      end
      RUN: begin
        tmo_cnt_d = tmo_cnt_q + 1'b1;
        if (AES_data_out_valid) begin
          en_d      = 1'b0;
          blocks_d  = blocks_q + 1'b1;
          gap_cnt_d = '0;
          state_d   = GAP;
        end else if (tmo_cnt_q == TMO_LAST) begin
          en_d      = 1'b0;
          terr_d    = 1'b1;
          gap_cnt_d = '0;
          state_d   = GAP;
        end
      end
      GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d  = COLLECT;
          clr_data = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = COLLECT;
    endcase
    busy_d = (state_d != COLLECT);
  end

  // Sequencer registers; reset drops AES_en on the same edge.
  always_ff @(posedge AES_clk) begin
    if (AES_rst) begin
      state_q   <= COLLECT;
      en_q      <= 1'b0;
      tmo_cnt_q <= '0;
      gap_cnt_q <= '0;
      blocks_q  <= '0;
      terr_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      en_q      <= en_d;
      tmo_cnt_q <= tmo_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      blocks_q  <= blocks_d;
      terr_q    <= terr_d;
      busy_q    <= busy_d;
    end
  end

  assign AES_en      = en_q;
  assign busy        = busy_q;
  assign timeout_err = terr_q;
  assign blocks_done = blocks_q;

endmodule
